// File: rtl/example3_response_checker_if.sv
// Bundle between the example3 stimulus side and the response checker: stimulus, DUT output
// and the checker's status/statistics.
interface example3_response_checker_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic             sample_req;
    logic             x;
    logic             y;
    logic             z;
    logic             a;
    logic             busy;
    logic             sample_ack;
    logic             mismatch;
    logic [CNT_W-1:0] vec_count;
    logic [CNT_W-1:0] err_count;
    logic [7:0]       cov_mask;
    logic             cov_full;
    logic [2:0]       first_err_vec;
    logic             first_err_valid;
    logic             overrun;

    modport master (
        output start, sample_req, x, y, z, a,
        input  busy, sample_ack, mismatch, vec_count, err_count, cov_mask, cov_full,
               first_err_vec, first_err_valid, overrun
    );

    modport slave (
        input  start, sample_req, x, y, z, a,
        output busy, sample_ack, mismatch, vec_count, err_count, cov_mask, cov_full,
               first_err_vec, first_err_valid, overrun
    );
endinterface

// File: rtl/example3_response_checker.sv
// example3 response checker: samples x,y,z,a a settle time after each request, compares a
// against (y ^ z) & (z | ~x), and keeps counts, input coverage and the first failing vector.
module example3_response_checker #(
    parameter int SETTLE_CYC = 2,
    parameter int CNT_W      = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    example3_response_checker_if.slave bus
);
    localparam int                WAIT_W    = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC + 1);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(SETTLE_CYC);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        COMPARE = 2'd2
    } state_t;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              busy_r;

    logic              vld_p0;
    logic [2:0]        xyz_p0;
    logic              a_p0;
    logic              mis_p0;

    logic              vld_p1;
    logic              mismatch_p1;
    logic [CNT_W-1:0]  vec_count;
    logic [CNT_W-1:0]  err_count;
    logic [7:0]        cov_mask;
    logic [2:0]        first_err_vec;
    logic              first_err_valid;
    logic              overrun;

    function automatic logic golden(input logic [2:0] xyz);
        return (xyz[1] ^ xyz[0]) & (xyz[0] | ~xyz[2]);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // Stage p0: capture the vector while in COMPARE; qualified by vld_p0
    always_ff @(posedge clk) begin
        if (state == COMPARE) begin
            xyz_p0 <= {bus.x, bus.y, bus.z};
            a_p0   <= bus.a;
        end
    end

    assign mis_p0 = vld_p0 & (a_p0 != golden(xyz_p0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            wait_cnt        <= '0;
            busy_r          <= 1'b0;
            vld_p0          <= 1'b0;
            vld_p1          <= 1'b0;
            mismatch_p1     <= 1'b0;
            vec_count       <= '0;
            err_count       <= '0;
            cov_mask        <= '0;
            first_err_vec   <= '0;
            first_err_valid <= 1'b0;
            overrun         <= 1'b0;
        end else if (bus.start) begin
            state           <= IDLE;
            wait_cnt        <= '0;
            busy_r          <= 1'b0;
            vld_p0          <= 1'b0;
            vld_p1          <= 1'b0;
            mismatch_p1     <= 1'b0;
            vec_count       <= '0;
            err_count       <= '0;
            cov_mask        <= '0;
            first_err_vec   <= '0;
            first_err_valid <= 1'b0;
            overrun         <= 1'b0;
        end else begin
            vld_p0 <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.sample_req) begin
                        busy_r <= 1'b1;
                        if (SETTLE_CYC == 0) begin
                            state <= COMPARE;
                        end else begin
                            state    <= SETTLE;
                            wait_cnt <= WAIT_LOAD;
                        end
                    end
                end
                SETTLE: begin
                    if (bus.sample_req) overrun <= 1'b1;
                    if (wait_cnt == WAIT_W'(1)) state <= COMPARE;
                    wait_cnt <= wait_cnt - WAIT_W'(1);
                end
                COMPARE: begin
                    if (bus.sample_req) overrun <= 1'b1;
                    vld_p0 <= 1'b1;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase

            // Stage p1: ack, mismatch and statistics from the captured vector
            vld_p1      <= vld_p0;
            mismatch_p1 <= mis_p0;
            if (vld_p0) begin
                vec_count        <= sat_inc(vec_count);
                cov_mask[xyz_p0] <= 1'b1;
                if (mis_p0) begin
                    err_count <= sat_inc(err_count);
                    if (!first_err_valid) begin
                        first_err_vec   <= xyz_p0;
                        first_err_valid <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.busy            = busy_r;
    assign bus.sample_ack      = vld_p1;
    assign bus.mismatch        = mismatch_p1;
    assign bus.vec_count       = vec_count;
    assign bus.err_count       = err_count;
    assign bus.cov_mask        = cov_mask;
    assign bus.cov_full        = &cov_mask;
    assign bus.first_err_vec   = first_err_vec;
    assign bus.first_err_valid = first_err_valid;
    assign bus.overrun         = overrun;
endmodule

// File: tb/tb_example3_response_checker.sv
// Directed bench for example3_response_checker: main instance (SETTLE_CYC=2, CNT_W=8), a
// CNT_W=2 instance for saturation and a SETTLE_CYC=0 instance for minimum latency.
module tb_example3_response_checker;
    logic clk = 1'b0;
    logic rst_n;
    logic start, sample_req, x, y, z, a;
    int   errors = 0;
    int   checks = 0;

    typedef struct {
        logic [2:0] xyz;
        logic       a;
        logic       exp_mis;
    } vec_t;

    vec_t tbl [14];

    always #5 clk = ~clk;

    example3_response_checker_if #(.CNT_W(8)) m_if ();
    example3_response_checker_if #(.CNT_W(2)) s_if ();
    example3_response_checker_if #(.CNT_W(8)) z_if ();

    assign {m_if.start, m_if.sample_req, m_if.x, m_if.y, m_if.z, m_if.a} = {start, sample_req, x, y, z, a};
    assign {s_if.start, s_if.sample_req, s_if.x, s_if.y, s_if.z, s_if.a} = {start, sample_req, x, y, z, a};
    assign {z_if.start, z_if.sample_req, z_if.x, z_if.y, z_if.z, z_if.a} = {start, sample_req, x, y, z, a};

    example3_response_checker #(.SETTLE_CYC(2), .CNT_W(8)) u_main (.clk(clk), .rst_n(rst_n), .bus(m_if));
    example3_response_checker #(.SETTLE_CYC(2), .CNT_W(2)) u_sat  (.clk(clk), .rst_n(rst_n), .bus(s_if));
    example3_response_checker #(.SETTLE_CYC(0), .CNT_W(8)) u_zero (.clk(clk), .rst_n(rst_n), .bus(z_if));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_main_clear(input string tag);
        check({tag, " busy"},            m_if.busy, 0);
        check({tag, " sample_ack"},      m_if.sample_ack, 0);
        check({tag, " mismatch"},        m_if.mismatch, 0);
        check({tag, " vec_count"},       m_if.vec_count, 0);
        check({tag, " err_count"},       m_if.err_count, 0);
        check({tag, " cov_mask"},        m_if.cov_mask, 0);
        check({tag, " cov_full"},        m_if.cov_full, 0);
        check({tag, " first_err_vec"},   m_if.first_err_vec, 0);
        check({tag, " first_err_valid"}, m_if.first_err_valid, 0);
        check({tag, " overrun"},         m_if.overrun, 0);
    endtask

    task automatic do_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Called #1 after the edge that accepted the request; lat counts edges until main ack.
    task automatic wait_ack(output int lat, output logic mis, output int lat_z);
        lat   = 0;
        lat_z = -1;
        while (m_if.sample_ack !== 1'b1 && lat < 12) begin
            @(posedge clk); #1;
            lat++;
            if (z_if.sample_ack === 1'b1 && lat_z < 0) lat_z = lat;
        end
        mis = m_if.mismatch;
    endtask

    task automatic send_vec(input logic [2:0] v, input logic av,
                            output int lat, output logic mis, output int lat_z);
        @(posedge clk); #1;
        {x, y, z}  = v;
        a          = av;
        sample_req = 1'b1;
        @(posedge clk); #1;
        sample_req = 1'b0;
        wait_ack(lat, mis, lat_z);
    endtask

    task automatic run_range(input int first, input int last);
        int   lat;
        int   lat_z;
        logic mis;
        for (int i = first; i <= last; i++) begin
            send_vec(tbl[i].xyz, tbl[i].a, lat, mis, lat_z);
            check($sformatf("vec%0d latency", i), lat, 4);
            check($sformatf("vec%0d mismatch", i), mis, tbl[i].exp_mis);
            check($sformatf("vec%0d zero-settle latency", i), lat_z, 2);
        end
    endtask

    initial begin
        int   lat;
        int   lat_z;
        int   acks;
        logic mis;

        tbl[0]  = '{3'b000, 1'b0, 1'b0};
        tbl[1]  = '{3'b101, 1'b1, 1'b0};
        tbl[2]  = '{3'b110, 1'b0, 1'b0};
        tbl[3]  = '{3'b011, 1'b0, 1'b0};
        tbl[4]  = '{3'b110, 1'b1, 1'b1};
        tbl[5]  = '{3'b000, 1'b1, 1'b1};
        tbl[6]  = '{3'b000, 1'b0, 1'b0};
        tbl[7]  = '{3'b001, 1'b1, 1'b0};
        tbl[8]  = '{3'b010, 1'b1, 1'b0};
        tbl[9]  = '{3'b011, 1'b0, 1'b0};
        tbl[10] = '{3'b100, 1'b0, 1'b0};
        tbl[11] = '{3'b101, 1'b1, 1'b0};
        tbl[12] = '{3'b110, 1'b0, 1'b0};
        tbl[13] = '{3'b111, 1'b0, 1'b0};

        rst_n = 1'b0;
        start = 1'b0; sample_req = 1'b0;
        x = 1'b0; y = 1'b0; z = 1'b0; a = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_main_clear("power-on reset");
        rst_n = 1'b1;

        // Four correct vectors, 6 cycles apart
        run_range(0, 3);
        check("t2 err_count", m_if.err_count, 0);
        check("t2 vec_count", m_if.vec_count, 4);
        check("t2 cov_mask",  m_if.cov_mask, 8'h69);
        check("t2 overrun",   m_if.overrun, 0);

        // Two wrong responses; first one is remembered
        do_start();
        run_range(4, 5);
        check("t3 err_count",       m_if.err_count, 2);
        check("t3 vec_count",       m_if.vec_count, 2);
        check("t3 first_err_vec",   m_if.first_err_vec, 3'b110);
        check("t3 first_err_valid", m_if.first_err_valid, 1);

        // Asynchronous reset while a check is in SETTLE
        @(posedge clk); #1;
        {x, y, z} = 3'b101; a = 1'b1; sample_req = 1'b1;
        @(posedge clk); #1;
        sample_req = 1'b0;
        check("pre-reset busy", m_if.busy, 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_main_clear("mid-run reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // All eight input combinations
        run_range(6, 12);
        check("t4 cov_full before 8th", m_if.cov_full, 0);
        check("t4 cov_mask before 8th", m_if.cov_mask, 8'h7F);
        run_range(13, 13);
        check("t4 cov_full",  m_if.cov_full, 1);
        check("t4 cov_mask",  m_if.cov_mask, 8'hFF);
        check("t4 err_count", m_if.err_count, 0);
        check("t4 vec_count", m_if.vec_count, 8);

        // Back-to-back requests: second one is an overrun
        do_start();
        @(posedge clk); #1;
        {x, y, z} = 3'b000; a = 1'b0; sample_req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        sample_req = 1'b0;
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (m_if.sample_ack === 1'b1) acks++;
        end
        check("t5 ack pulses", acks, 1);
        check("t5 overrun",    m_if.overrun, 1);
        check("t5 vec_count",  m_if.vec_count, 1);
        do_start();
        check("t5 overrun after start", m_if.overrun, 0);

        // Request raised in the ack cycle is accepted
        send_vec(3'b001, 1'b1, lat, mis, lat_z);
        check("ack-cycle first latency", lat, 4);
        {x, y, z} = 3'b010; a = 1'b1; sample_req = 1'b1;
        @(posedge clk); #1;
        sample_req = 1'b0;
        wait_ack(lat, mis, lat_z);
        check("ack-cycle second latency", lat, 4);
        check("ack-cycle vec_count",      m_if.vec_count, 2);
        check("ack-cycle overrun",        m_if.overrun, 0);
        check("ack-cycle err_count",      m_if.err_count, 0);

        // Saturation at CNT_W=2, then start during SETTLE
        do_start();
        for (int i = 0; i < 5; i++) begin
            send_vec(3'b000, 1'b1, lat, mis, lat_z);
            check($sformatf("sat vec%0d mismatch", i), s_if.mismatch, 1);
        end
        check("sat err_count",       s_if.err_count, 3);
        check("sat vec_count",       s_if.vec_count, 3);
        check("sat first_err_valid", s_if.first_err_valid, 1);
        check("main err_count 5",    m_if.err_count, 5);

        @(posedge clk); #1;
        {x, y, z} = 3'b101; a = 1'b0; sample_req = 1'b1;
        @(posedge clk); #1;
        sample_req = 1'b0;
        check("sat busy in SETTLE", s_if.busy, 1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start busy",            s_if.busy, 0);
        check("start err_count",       s_if.err_count, 0);
        check("start vec_count",       s_if.vec_count, 0);
        check("start cov_mask",        s_if.cov_mask, 0);
        check("start first_err_valid", s_if.first_err_valid, 0);
        check("start first_err_vec",   s_if.first_err_vec, 0);
        check("start overrun",         s_if.overrun, 0);
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (s_if.sample_ack === 1'b1 || m_if.sample_ack === 1'b1) acks++;
        end
        check("start suppressed acks", acks, 0);
        check_main_clear("after start");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
        $fatal(1, "watchdog");
    end
endmodule
